// File: rtl/adder_pkg.sv
// Shared defaults and parameter legality for the pipelined carry-select adder.
// Pure definitions: no logic, no latency, no handshake.
package adder_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int STAGES_DEF = 4;

   // Every stage must own an equal, non-empty slice of the operand.
   function automatic bit params_ok(input int width, input int stages);
      return (stages > 0) && (width >= stages) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/csel_slice.sv
// One carry-select slice: sums for carry-in 0 and 1 built in parallel, cin picks one.
// Purely combinational, no handshake; the enclosing pipeline registers cin and cout.
module csel_slice
   import adder_pkg::*;
#(
   parameter int SLICE = WIDTH_DEF / STAGES_DEF
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE:0] sum0;
   logic [SLICE:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, 1'b1};

   assign {cout, s} = cin ? sum1 : sum0;

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined add/sub: slice k resolves in stage k, operands skewed in, sums de-skewed out.
// Latency STAGES cycles, one op per cycle; a stalled output freezes all stages (in_ready = en).
module pipe_csel_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STAGES = STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SLICE = WIDTH / STAGES;

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("pipe_csel_adder: WIDTH must be a positive multiple of STAGES");
   end

   logic [WIDTH-1:0]  b_eff;
   logic              c_in0;
   logic              en;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] cin_w;
   logic [STAGES-1:0] cout_w;
   logic [WIDTH-1:0]  s_fin;
   logic              a_top;
   logic              b_top;

   // Subtract as A + ~B + ~Cin so a borrow-in maps onto the adder carry-in.
   assign b_eff     = Sub ? ~B : B;
   assign c_in0     = Sub ? ~Cin : Cin;
   assign en        = !v_q[STAGES-1] || out_ready;
   assign in_ready  = en;
   assign out_valid = v_q[STAGES-1];
   assign Cout      = c_q[STAGES-1];

   for (genvar j = 0; j < STAGES; j++) begin : g_slice
      logic [SLICE-1:0] a_op;
      logic [SLICE-1:0] b_op;
      logic [SLICE-1:0] s_op;

      if (j == 0) begin : g_direct
         assign a_op     = A[SLICE-1:0];
         assign b_op     = b_eff[SLICE-1:0];
         assign cin_w[0] = c_in0;
      end else begin : g_skew
         logic [SLICE-1:0] a_d [j];
         logic [SLICE-1:0] b_d [j];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < j; d++) begin
                  a_d[d] <= '0;
                  b_d[d] <= '0;
               end
            end else if (en) begin
               a_d[0] <= A[j*SLICE +: SLICE];
               b_d[0] <= b_eff[j*SLICE +: SLICE];
               for (int d = 1; d < j; d++) begin
                  a_d[d] <= a_d[d-1];
                  b_d[d] <= b_d[d-1];
               end
            end
         end

         assign a_op     = a_d[j-1];
         assign b_op     = b_d[j-1];
         assign cin_w[j] = c_q[j-1];
      end

      csel_slice #(.SLICE(SLICE)) u_csel (
         .a    (a_op),
         .b    (b_op),
         .cin  (cin_w[j]),
         .s    (s_op),
         .cout (cout_w[j])
      );

      if (j == STAGES-1) begin : g_last
         assign s_fin[j*SLICE +: SLICE] = s_op;
         assign a_top = a_op[SLICE-1];
         assign b_top = b_op[SLICE-1];
      end else begin : g_sdly
         // Early slices wait here until the top slice catches up.
         logic [SLICE-1:0] s_d [STAGES-1-j];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < STAGES-1-j; d++) begin
                  s_d[d] <= '0;
               end
            end else if (en) begin
               s_d[0] <= s_op;
               for (int d = 1; d < STAGES-1-j; d++) begin
                  s_d[d] <= s_d[d-1];
               end
            end
         end

         assign s_fin[j*SLICE +: SLICE] = s_d[STAGES-2-j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= '0;
         c_q  <= '0;
         S    <= '0;
         Ovf  <= 1'b0;
         Zero <= 1'b0;
      end else if (en) begin
         v_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         c_q  <= cout_w;
         S    <= s_fin;
         Ovf  <= (a_top == b_top) && (s_fin[WIDTH-1] != a_top);
         Zero <= (s_fin == '0);
      end
   end

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Randomised and directed bench for pipe_csel_adder (32/4 and 16/2 builds) against an arithmetic model.
`timescale 1ns/1ps
module tb_pipe_csel_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [31:0] a, b, s;
   logic        cin, sub, in_valid, in_ready, cout, ovf, zero, out_valid, out_ready;

   logic [15:0] a16, b16, s16;
   logic        cin16, sub16, in_valid16, in_ready16, cout16, ovf16, zero16, out_valid16, out_ready16;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   res_t exp_q[$];
   res_t obs_q[$];
   int   exp_cyc[$];
   int   obs_cyc[$];

   pipe_csel_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .Sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .S(s), .Cout(cout), .Ovf(ovf),
      .Zero(zero), .out_valid(out_valid), .out_ready(out_ready)
   );

   pipe_csel_adder #(.WIDTH(16), .STAGES(2)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .Sub(sub16),
      .in_valid(in_valid16), .in_ready(in_ready16), .S(s16), .Cout(cout16), .Ovf(ovf16),
      .Zero(zero16), .out_valid(out_valid16), .out_ready(out_ready16)
   );

   // Plain integer arithmetic: unsigned result for S/Cout, signed result for Ovf.
   function automatic res_t model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                  input logic xc, input logic xs);
      longint m  = longint'(1) << w;
      longint ua = longint'(xa) & (m - 1);
      longint ub = longint'(xb) & (m - 1);
      longint sa = (ua >= m / 2) ? ua - m : ua;
      longint sb = (ub >= m / 2) ? ub - m : ub;
      longint ci = xc ? 1 : 0;
      longint r;
      longint sr;
      res_t   o;
      if (!xs) begin
         r      = ua + ub + ci;
         sr     = sa + sb + ci;
         o.cout = (r >= m);
      end else begin
         r      = ua - ub - ci;
         sr     = sa - sb - ci;
         o.cout = (r >= 0);
      end
      r      = r & (m - 1);
      o.s    = 32'(r);
      o.ovf  = (sr >= m / 2) || (sr < -(m / 2));
      o.zero = (r == 0);
      return o;
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic clear_sb();
      exp_q.delete();
      obs_q.delete();
      exp_cyc.delete();
      obs_cyc.delete();
   endtask

   // One clock of stimulus on the selected build; records accepted ops (as model results) and delivered outputs.
   task automatic cycle(input bit d16, input bit iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, input bit ordy);
      @(negedge clk);
      in_valid    = iv && !d16;
      in_valid16  = iv && d16;
      a = ia;  b = ib;  cin = ic;  sub = is;
      a16 = ia[15:0];  b16 = ib[15:0];  cin16 = ic;  sub16 = is;
      out_ready   = d16 ? 1'b1 : ordy;
      out_ready16 = d16 ? ordy : 1'b1;
      #1;
      if (!d16) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model(32, a, b, cin, sub));
            exp_cyc.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            obs_q.push_back('{s, cout, ovf, zero});
            obs_cyc.push_back(cyc);
         end
      end else begin
         if (in_valid16 && in_ready16) begin
            exp_q.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
            exp_cyc.push_back(cyc);
         end
         if (out_valid16 && out_ready16) begin
            obs_q.push_back('{{16'h0, s16}, cout16, ovf16, zero16});
            obs_cyc.push_back(cyc);
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (s !== 32'h0) begin failures++; $display("FAIL reset_s: got %h want 0", s); end
      checks++; if ({cout, ovf, zero} !== 3'b000) begin failures++; $display("FAIL reset_flags: got cout/ovf/zero=%b want 000", {cout, ovf, zero}); end
      checks++; if ({out_valid16, in_ready16, zero16} !== 3'b010) begin failures++; $display("FAIL reset16: got valid/ready/zero=%b want 010", {out_valid16, in_ready16, zero16}); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL post_reset: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_directed();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic [31:0] vs [7];
      logic        vc [7];
      logic        vsub [7];
      logic        vco [7];
      logic        vov [7];
      logic        vz [7];
      va   = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd5, 32'd3, 32'd5};
      vb   = '{32'h1, 32'h1, 32'h1, 32'd3, 32'd3, 32'd5, 32'd5};
      vc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vsub = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vs   = '{32'h0, 32'h80000000, 32'h7FFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 32'h0};
      vco  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vov  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vz   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int t = 0; t < 7; t++) begin
         clear_sb();
         cycle(1'b0, 1'b1, va[t], vb[t], vc[t], vsub[t], 1'b1);
         for (int n = 0; n < 12 && obs_q.size() == 0; n++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
         checks++;
         if (obs_q.size() != 1 || exp_q.size() != 1) begin
            failures++; $display("FAIL dir%0d_count: got %0d outputs / %0d accepts want 1/1", t, obs_q.size(), exp_q.size());
         end else begin
            checks++; if (obs_q[0].s !== vs[t]) begin failures++; $display("FAIL dir%0d_s: got %h want %h", t, obs_q[0].s, vs[t]); end
            checks++; if (obs_q[0].cout !== vco[t]) begin failures++; $display("FAIL dir%0d_cout: got %b want %b", t, obs_q[0].cout, vco[t]); end
            checks++; if (obs_q[0].ovf !== vov[t]) begin failures++; $display("FAIL dir%0d_ovf: got %b want %b", t, obs_q[0].ovf, vov[t]); end
            checks++; if (obs_q[0].zero !== vz[t]) begin failures++; $display("FAIL dir%0d_zero: got %b want %b", t, obs_q[0].zero, vz[t]); end
            checks++; if (obs_cyc[0] - exp_cyc[0] != 4) begin failures++; $display("FAIL dir%0d_latency: got %0d want 4", t, obs_cyc[0] - exp_cyc[0]); end
         end
      end
   endtask

   task automatic test_back_to_back(input bit d16);
      int lat = d16 ? 2 : 4;
      clear_sb();
      for (int i = 0; i < 8; i++) cycle(d16, 1'b1, 32'(i), 32'(i), i[0], 1'b0, 1'b1);
      for (int n = 0; n < 20 && obs_q.size() < 8; n++) cycle(d16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_q.size() != 8 || exp_q.size() != 8) begin
         failures++; $display("FAIL b2b%0d_count: got %0d outputs / %0d accepts want 8/8", d16, obs_q.size(), exp_q.size());
      end else begin
         checks++; if (obs_cyc[0] - exp_cyc[0] != lat) begin failures++; $display("FAIL b2b%0d_latency: got %0d want %0d", d16, obs_cyc[0] - exp_cyc[0], lat); end
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         checks++; if (obs_q[i].s !== 32'(2 * i + (i % 2))) begin failures++; $display("FAIL b2b%0d_s[%0d]: got %h want %h", d16, i, obs_q[i].s, 32'(2 * i + (i % 2))); end
         if (i > 0) begin
            checks++; if (obs_cyc[i] != obs_cyc[i-1] + 1) begin failures++; $display("FAIL b2b%0d_gap[%0d]: got cycle %0d want %0d", d16, i, obs_cyc[i], obs_cyc[i-1] + 1); end
         end
      end
   endtask

   task automatic test_stall();
      res_t held;
      clear_sb();
      for (int n = 0; n < 4; n++) cycle(1'b0, 1'b1, rnd32(), rnd32(), 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b0, 1'b1, rnd32(), rnd32(), 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_entry: got valid=%b ready=%b want 1/0", out_valid, in_ready); end
      held = '{s, cout, ovf, zero};
      for (int n = 0; n < 4; n++) begin
         cycle(1'b0, 1'b1, rnd32(), rnd32(), 1'($urandom), 1'($urandom), 1'b0);
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %b want 0", n, in_ready); end
         checks++;
         if ({s, cout, ovf, zero} !== held || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold[%0d]: got s=%h flags=%b valid=%b want s=%h flags=%b valid=1", n, s, {cout, ovf, zero}, out_valid, held.s, {held.cout, held.ovf, held.zero});
         end
      end
      checks++; if (exp_q.size() != 4) begin failures++; $display("FAIL stall_accepts: got %0d want 4", exp_q.size()); end
      for (int n = 0; n < 20 && obs_q.size() < 4; n++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL stall_count: got %0d outputs want 4", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random(input bit d16, input int n_ops);
      clear_sb();
      for (int n = 0; n < n_ops; n++)
         cycle(d16, $urandom_range(0, 3) != 0, rnd32(), rnd32(), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      for (int n = 0; n < 40 && obs_q.size() < exp_q.size(); n++) cycle(d16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count: got %0d outputs want %0d", d16, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL rand%0d_data[%0d]: got s=%h c/o/z=%b want s=%h c/o/z=%b", d16, i, obs_q[i].s, {obs_q[i].cout, obs_q[i].ovf, obs_q[i].zero}, exp_q[i].s, {exp_q[i].cout, exp_q[i].ovf, exp_q[i].zero});
         end
      end
   endtask

   task automatic test_reset_midflight();
      clear_sb();
      for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, rnd32(), rnd32(), 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre: got out_valid=%b want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      checks++; if (s !== 32'h0 || zero !== 1'b0) begin failures++; $display("FAIL midrst_s: got s=%h zero=%b want 0/0", s, zero); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      repeat (10) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_stale: got %0d outputs want 0", obs_q.size()); end
      cycle(1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
      for (int n = 0; n < 12 && obs_q.size() == 0; n++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         failures++; $display("FAIL midrst_new_count: got %0d outputs want 1", obs_q.size());
      end else begin
         checks++; if (obs_q[0].s !== 32'h2345_678A) begin failures++; $display("FAIL midrst_new_s: got %h want 2345678a", obs_q[0].s); end
         checks++; if (obs_cyc[0] - exp_cyc[0] != 4) begin failures++; $display("FAIL midrst_new_latency: got %0d want 4", obs_cyc[0] - exp_cyc[0]); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached with checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a = '0;  b = '0;  cin = 1'b0;  sub = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      a16 = '0;  b16 = '0;  cin16 = 1'b0;  sub16 = 1'b0;  in_valid16 = 1'b0;  out_ready16 = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back(1'b0);
      test_stall();
      test_random(1'b0, 300);
      test_reset_midflight();
      test_back_to_back(1'b1);
      test_random(1'b1, 200);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_csel_adder.md
PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0; SLICE = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports A, B  input  WIDTH  operands.
REQ-006 SHALL have port Cin  input  1  carry-in (add) / borrow-in (sub).
REQ-007 SHALL have port Sub  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1  input handshake.
REQ-009 SHALL have port S  output  WIDTH  result.
REQ-010 SHALL have port Cout  output  1  raw carry-out of final slice.
REQ-011 SHALL have ports Ovf output 1 (signed overflow), Zero output 1 (S == 0).
REQ-012 SHALL have ports out_valid output 1, out_ready input 1  output handshake.

Function
REQ-013 SHALL compute {Cout,S} = A + B + Cin when Sub=0; A + ~B + ~Cin when Sub=1, i.e. A - B - Cin.
REQ-014 SHALL set Ovf = (A[MSB] == Beff[MSB]) && (S[MSB] != A[MSB]), where Beff is the post-inversion B.
REQ-015 SHALL process slice k (bits k*SLICE..k*SLICE+SLICE-1) in stage k, each using a carry-select slice (both carry-in hypotheses computed, stage carry register selects).
REQ-016 SHALL skew operands: slice k operand bits delayed k stages; completed sum slices delayed STAGES-1-k stages so S emerges aligned.
REQ-017 SHALL have latency exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid with no stall.
REQ-018 SHALL sustain one accepted operation per cycle when out_ready stays high.
REQ-019 SHALL advance all stages together under global enable en = !out_valid || out_ready; in_ready = en.
REQ-020 SHALL hold S, Cout, Ovf, Zero, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL insert a bubble (valid bit 0) into stage 0 on any enabled cycle with in_valid=0.
REQ-022 SHALL ignore A, B, Cin, Sub when in_valid=0 or in_ready=0.
REQ-023 SHALL, when STAGES=1, behave as a single registered adder with latency 1.
REQ-024 SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear all stage valid bits, carry registers, S, Cout, Ovf to 0 and set Zero to 0.
REQ-026 SHALL discard all in-flight operations on reset mid-operation; no out_valid until new inputs fully traverse the pipeline.
REQ-027 SHALL drive in_ready=1 during and immediately after reset.

Structure
REQ-028 SHALL place WIDTH/STAGES defaults and the parameter-legality check in shared package adder_pkg.
REQ-029 SHALL instantiate STAGES copies of sub-module csel_slice (parameter SLICE; ports a, b, cin, s, cout, combinational carry-select).
REQ-030 SHALL contain all sequential logic (skew registers, valid chain, handshake) in pipe_csel_adder only.

Verification
REQ-031 SHALL check A=FFFFFFFF, B=00000001, Cin=0, Sub=0 -> S=00000000, Cout=1, Ovf=0, Zero=1 after 4 cycles.
REQ-032 SHALL check A=7FFFFFFF, B=00000001, Sub=0 -> S=80000000, Ovf=1, Cout=0; A=80000000, B=00000001, Sub=1, Cin=0 -> S=7FFFFFFF, Ovf=1.
REQ-033 SHALL check Sub=1: A=5, B=3, Cin=0 -> S=2; Cin=1 -> S=1; A=3, B=5, Cin=0 -> S=FFFFFFFE, Cout=0.
REQ-034 SHALL check 8 back-to-back inputs (A=i, B=i, Cin=i[0]) with out_ready=1 -> 8 outputs on consecutive cycles, S=2i+i[0], in order.
REQ-035 SHALL check out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, S held, no loss or duplication after release.
REQ-036 SHALL check rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, no stale output afterwards, WIDTH=16/STAGES=2 rerun passes REQ-034.
